cpu_dbg_streamer: RTL and testbench

// - Downstream consumer of the cpu top's eight 32-bit debug outputs (data_out0..7).
// - On a trigger, snapshots all eight words and streams them as one byte-wide frame

---
 rtl/cpu_dbg_streamer.sv | 133 +++++++++++++
 tb/tb_cpu_dbg_streamer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dbg_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_dbg_streamer: snapshots eight 32-bit debug words on trig and     |
// | streams header, 32 data bytes and optional checksum over valid/ready |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cpu_dbg_streamer #(
  parameter logic [7:0] HEADER  = 8'hA5,
  parameter bit         CSUM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig,
  input  logic [31:0] data_in0,
  input  logic [31:0] data_in1,
  input  logic [31:0] data_in2,
  input  logic [31:0] data_in3,
  input  logic [31:0] data_in4,
  input  logic [31:0] data_in5,
  input  logic [31:0] data_in6,
  input  logic [31:0] data_in7,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2,
    S_CSUM = 2'd3
  } state_t;

  localparam logic [4:0] c_last_idx = 5'd31;

  state_t      r_state;
  logic [31:0] r_snap [8];
  logic [4:0]  r_cnt;
  logic [7:0]  r_csum;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_busy;

  logic [31:0] w_din [8];
  logic [4:0]  w_nxt_idx;
  logic [31:0] w_nxt_word;
  logic [7:0]  w_nxt_byte;
  logic [7:0]  w_csum_nxt;
  logic        w_xfer;

  always_comb begin
    w_din[0] = data_in0;
    w_din[1] = data_in1;
    w_din[2] = data_in2;
    w_din[3] = data_in3;
    w_din[4] = data_in4;
    w_din[5] = data_in5;
    w_din[6] = data_in6;
    w_din[7] = data_in7;
  end

  // Byte k+1 is preloaded so the next byte is ready on the transfer of byte k.
  assign w_nxt_idx  = r_cnt + 5'd1;
  assign w_nxt_word = r_snap[w_nxt_idx[4:2]];
  assign w_nxt_byte = w_nxt_word[{w_nxt_idx[1:0], 3'b000} +: 8];
  assign w_csum_nxt = r_csum + r_out_data;
  assign w_xfer     = r_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_csum      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int i = 0; i < 8; i++) r_snap[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trig) begin
            for (int i = 0; i < 8; i++) r_snap[i] <= w_din[i];
            r_cnt       <= '0;
            r_csum      <= '0;
            r_state     <= S_HDR;
            r_out_data  <= HEADER;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            r_state    <= S_DATA;
            r_out_data <= r_snap[0][7:0];
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_csum <= w_csum_nxt;
            if (r_cnt == c_last_idx) begin
              if (CSUM_EN) begin
                r_state    <= S_CSUM;
                r_out_data <= w_csum_nxt;
              end else begin
                r_state     <= S_IDLE;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
              end
            end else begin
              r_cnt      <= w_nxt_idx;
              r_out_data <= w_nxt_byte;
            end
          end
        end
        S_CSUM: begin
          if (w_xfer) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cpu_dbg_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu_dbg_streamer: frame-level reference model for both checksum   |
// | variants, plus literal frame expectations                            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cpu_dbg_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig;
  logic        out_ready;
  logic [31:0] din [8];
  logic [7:0]  od [2];
  logic        ov [2];
  logic        ob [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_dbg_streamer #(.HEADER(8'hA5), .CSUM_EN(1'b1)) u_dut_csum (
    .clk(clk), .rst(rst), .trig(trig),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
    .out_data(od[0]), .out_valid(ov[0]), .out_ready(out_ready), .busy(ob[0])
  );

  cpu_dbg_streamer #(.HEADER(8'hA5), .CSUM_EN(1'b0)) u_dut_nocsum (
    .clk(clk), .rst(rst), .trig(trig),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .data_in4(din[4]), .data_in5(din[5]), .data_in6(din[6]), .data_in7(din[7]),
    .out_data(od[1]), .out_valid(ov[1]), .out_ready(out_ready), .busy(ob[1])
  );

  // Model: a whole frame is computed as a byte list when it starts; pos walks it.
  logic [7:0] mf   [2][34];
  int         mlen [2];
  int         mpos [2];
  bit         mbusy[2];
  logic [7:0] log0[$];
  logic [7:0] log1[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void build_frame(int i);
    logic [7:0] sum;
    sum = 8'h00;
    mf[i][0] = 8'hA5;
    for (int k = 0; k < 32; k++) begin
      mf[i][k+1] = din[k/4][8*(k%4) +: 8];
      sum = sum + mf[i][k+1];
    end
    if (i == 0) begin
      mf[i][33] = sum;
      mlen[i] = 34;
    end else begin
      mlen[i] = 33;
    end
    mpos[i]  = 0;
    mbusy[i] = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        chk("rst_valid", 32'(ov[i]), 32'd0);
        chk("rst_busy", 32'(ob[i]), 32'd0);
        chk("rst_data", 32'(od[i]), 32'd0);
        mbusy[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk(i == 0 ? "valid_c" : "valid_n", 32'(ov[i]), 32'(mbusy[i]));
        chk(i == 0 ? "busy_c" : "busy_n", 32'(ob[i]), 32'(mbusy[i]));
        if (mbusy[i]) chk(i == 0 ? "data_c" : "data_n", 32'(od[i]), 32'(mf[i][mpos[i]]));
      end
      if (ov[0] && out_ready) log0.push_back(od[0]);
      if (ov[1] && out_ready) log1.push_back(od[1]);
      for (int i = 0; i < 2; i++) begin
        if (mbusy[i]) begin
          if (out_ready) begin
            mpos[i]++;
            if (mpos[i] == mlen[i]) mbusy[i] = 1'b0;
          end
        end else if (trig) begin
          build_frame(i);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while ((ob[0] || ob[1]) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(ob[0] | ob[1]), 32'd0);
  endtask

  initial begin
    logic all_ok;
    rst = 1'b1;
    trig = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = '0;
    for (int i = 0; i < 2; i++) begin mbusy[i] = 1'b0; mpos[i] = 0; mlen[i] = 0; end
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Frame 1: known pattern, trig pulses mid-frame and on the last transfer.
    din[0] = 32'h04030201;
    out_ready = 1'b1;
    log0.delete();
    log1.delete();
    trig = 1'b1;
    tick();
    for (int j = 1; j <= 34; j++) begin
      trig = (j == 3 || j == 10 || j == 34);
      tick();
    end
    trig = 1'b0;
    chk("f1_len", 32'(log0.size()), 32'd34);
    chk("f1_len_nocsum", 32'(log1.size()), 32'd33);
    if (log0.size() == 34) begin
      chk("f1_hdr", 32'(log0[0]), 32'hA5);
      chk("f1_b0", 32'(log0[1]), 32'h01);
      chk("f1_b1", 32'(log0[2]), 32'h02);
      chk("f1_b2", 32'(log0[3]), 32'h03);
      chk("f1_b3", 32'(log0[4]), 32'h04);
      all_ok = 1'b1;
      for (int k = 5; k < 33; k++) if (log0[k] !== 8'h00) all_ok = 1'b0;
      chk("f1_zeros", 32'(all_ok), 32'd1);
      chk("f1_csum", 32'(log0[33]), 32'h0A);
    end
    chk("f1_busy_low", 32'(ob[0]), 32'd0);

    // Frame 2: trig right after the checksum transfer, all-ones data, stalls.
    for (int i = 0; i < 8; i++) din[i] = 32'hFFFF_FFFF;
    log0.delete();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    for (int j = 0; j < 68; j++) begin
      out_ready = (j % 2 == 0);
      if (j == 20) for (int i = 0; i < 8; i++) din[i] = $urandom;
      tick();
    end
    out_ready = 1'b1;
    wait_idle(100);
    chk("f2_len", 32'(log0.size()), 32'd34);
    if (log0.size() == 34) begin
      chk("f2_hdr", 32'(log0[0]), 32'hA5);
      all_ok = 1'b1;
      for (int k = 1; k < 33; k++) if (log0[k] !== 8'hFF) all_ok = 1'b0;
      chk("f2_ones", 32'(all_ok), 32'd1);
      chk("f2_csum", 32'(log0[33]), 32'hE0);
    end

    // Reset while the data byte with k=10 is presented.
    for (int i = 0; i < 8; i++) din[i] = $urandom;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (11) tick();
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 32'(ov[0]), 32'd0);
    chk("rst_async_busy", 32'(ob[0]), 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("post_rst_idle", 32'(ov[0] | ov[1]), 32'd0);

    // Randomized traffic with data changing every cycle.
    for (int c = 0; c < 3000; c++) begin
      trig = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) din[i] = $urandom;
      tick();
    end
    trig = 1'b0;
    out_ready = 1'b1;
    wait_idle(200);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
